neopixel_encoder: RTL and testbench

Serialises a stream of GRB pixel words into the WS2812 single-wire waveform on a neopixel drive pin. Sits directly upstream of the `neopixel_drive1` output of `top`. Consumes pixels from the frame/pattern generator over a valid/ready handshake and terminates each frame with a latch (reset) low period. Runs entirely in the 125 MHz domain.

---
 rtl/neopixel_pkg.sv | 29 ++
 rtl/neopixel_cell_timer.sv | 69 ++++++
 rtl/neopixel_encoder.sv | 152 +++++++++++++++
 tb/tb_neopixel_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// neopixel_pkg: shared types and constants for the WS2812 encoder.
// Build option: define NEOPIXEL_RGBW_EN for 32-bit GRBW pixels,
// otherwise pixels are 24-bit GRB.
package neopixel_pkg;

  // Encoder top-level states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } np_state_e;

`ifdef NEOPIXEL_RGBW_EN
  localparam int PIXEL_BITS = 32;
`else
  localparam int PIXEL_BITS = 24;
`endif

  localparam int BITCNT_W = $clog2(PIXEL_BITS);

  // WS2812 timing at 125 MHz (8 ns per cycle)
  localparam int T0H_DEFAULT       = 50;    // 0.4 us
  localparam int T1H_DEFAULT       = 100;   // 0.8 us
  localparam int BIT_DEFAULT       = 156;   // 1.25 us
  localparam int LATCH_DEFAULT     = 10000; // 80 us
  // Shortened latch used by the instantiating level in sim builds
  localparam int LATCH_SIM_DEFAULT = 400;

endpackage

// File: rtl/neopixel_cell_timer.sv
// neopixel_cell_timer: times one WS2812 bit cell.
// A start strobe means the following cycle is count 0 of a new cell carrying
// bit_val. Without a fresh start at the end of a cell the timer goes idle
// and holds the line low. The drive level and end strobe are registered and
// computed from next-cycle values, so they line up with the counter cycle
// they describe. cell_end_next is the combinational look-ahead of cell_end.
module neopixel_cell_timer #(
  parameter int C_T0H_CYCLES = 50,
  parameter int C_T1H_CYCLES = 100,
  parameter int C_BIT_CYCLES = 156
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic drive,
  output logic cell_end,
  output logic cell_end_next
);

  localparam int CW = (C_BIT_CYCLES > 1) ? $clog2(C_BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(C_BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H_C  = CW'(C_T0H_CYCLES);
  localparam logic [CW-1:0] T1H_C  = CW'(C_T1H_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          bit_q, bit_d;
  logic          drive_q, drive_d;
  logic          end_q, end_d;
  logic [CW-1:0] thr;

  // Next-cycle counter, bit value and the registered outputs they imply
  always_comb begin
    active_d = active_q && (cnt_q != LAST_C);
    cnt_d    = active_d ? (cnt_q + CW'(1)) : '0;
    bit_d    = bit_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      bit_d    = bit_val;
    end
    thr     = bit_d ? T1H_C : T0H_C;
    drive_d = active_d && (cnt_d < thr);
    end_d   = active_d && (cnt_d == LAST_C);
  end

  // Cell timer state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      bit_q    <= 1'b0;
      drive_q  <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      bit_q    <= bit_d;
      drive_q  <= drive_d;
      end_q    <= end_d;
    end
  end

  assign drive         = drive_q;
  assign cell_end      = end_q;
  assign cell_end_next = end_d;

endmodule

// File: rtl/neopixel_encoder.sv
// neopixel_encoder: serialises GRB(W) pixel words into the WS2812 waveform.
// Pixel width follows NEOPIXEL_RGBW_EN (see neopixel_pkg).
// IDLE waits for a pixel, SEND shifts bits out MSB first through the cell
// timer, LATCH holds the line low to latch the strip. All outputs are flops.
module neopixel_encoder
  import neopixel_pkg::*;
#(
  parameter int C_T0H_CYCLES   = T0H_DEFAULT,
  parameter int C_T1H_CYCLES   = T1H_DEFAULT,
  parameter int C_BIT_CYCLES   = BIT_DEFAULT,
  parameter int C_LATCH_CYCLES = LATCH_DEFAULT
) (
  input  logic                  clock_125m,
  input  logic                  reset_125m,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  input  logic                  pixel_valid,
  input  logic                  pixel_last,
  output logic                  pixel_ready,
  output logic                  neopixel_drive,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int LW = (C_LATCH_CYCLES > 1) ? $clog2(C_LATCH_CYCLES) : 1;
  localparam logic [LW-1:0]       LAT_LAST_C = LW'(C_LATCH_CYCLES - 1);
  localparam logic [BITCNT_W-1:0] BIT_TOP_C  = BITCNT_W'(PIXEL_BITS - 1);

  np_state_e             state_q, state_d;
  logic [PIXEL_BITS-1:0] shreg_q, shreg_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic                  last_q, last_d;
  logic [LW-1:0]         latcnt_q, latcnt_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  fd_q, fd_d;
  logic                  ur_q, ur_d;

  logic hs;
  logic start;
  logic bit_in;
  logic tmr_drive;
  logic tmr_end;
  logic tmr_end_next;

  neopixel_cell_timer #(
    .C_T0H_CYCLES (C_T0H_CYCLES),
    .C_T1H_CYCLES (C_T1H_CYCLES),
    .C_BIT_CYCLES (C_BIT_CYCLES)
  ) u_cell_timer (
    .clk           (clock_125m),
    .rst           (reset_125m),
    .start         (start),
    .bit_val       (bit_in),
    .drive         (tmr_drive),
    .cell_end      (tmr_end),
    .cell_end_next (tmr_end_next)
  );

  // Next-state, shift register, handshake and registered output decode
  always_comb begin
    hs       = pixel_valid && ready_q;
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    last_d   = last_q;
    latcnt_d = latcnt_q;
    ur_d     = 1'b0;
    start    = 1'b0;
    // After a shift the next bit to send is the one just below the MSB
    bit_in   = shreg_q[PIXEL_BITS-2];

    unique case (state_q)
      ST_IDLE: begin
        // handled by the common load below
      end
      ST_SEND: begin
        if (tmr_end) begin
          if (bitcnt_q != '0) begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q - BITCNT_W'(1);
            start    = 1'b1;
          end else if (!hs) begin
            // Frame ends: either a marked last pixel or the source ran dry
            state_d  = ST_LATCH;
            latcnt_d = '0;
            ur_d     = !last_q;
          end
        end
      end
      ST_LATCH: begin
        if (latcnt_q == LAT_LAST_C) begin
          state_d  = ST_IDLE;
          latcnt_d = '0;
        end else begin
          latcnt_d = latcnt_q + LW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accepted word: the first cell starts next cycle with no gap
    if (hs) begin
      state_d  = ST_SEND;
      shreg_d  = pixel_data;
      last_d   = pixel_last;
      bitcnt_d = BIT_TOP_C;
      start    = 1'b1;
      bit_in   = pixel_data[PIXEL_BITS-1];
    end

    // Ready next cycle in IDLE, or when next cycle closes the final cell of a
    // pixel that was not marked last
    ready_d = (state_d == ST_IDLE) ||
              ((state_q == ST_SEND) && tmr_end_next &&
               (bitcnt_q == '0) && !last_q);
    busy_d  = (state_d != ST_IDLE);
    fd_d    = (state_d == ST_LATCH) && (latcnt_d == LAT_LAST_C);
  end

  // State and output registers
  always_ff @(posedge clock_125m) begin
    if (reset_125m) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      last_q   <= 1'b0;
      latcnt_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      fd_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      last_q   <= last_d;
      latcnt_q <= latcnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      fd_q     <= fd_d;
      ur_q     <= ur_d;
    end
  end

  assign pixel_ready    = ready_q;
  assign neopixel_drive = tmr_drive;
  assign busy           = busy_q;
  assign frame_done     = fd_q;
  assign underrun       = ur_q;

endmodule

// File: tb/tb_neopixel_encoder.sv
// tb_neopixel_encoder: random and directed frames against a pixel-position
// reference model, plus literal timing expectations from the test plan.
module tb_neopixel_encoder;
  import neopixel_pkg::*;

  localparam int T0H   = 2;
  localparam int T1H   = 4;
  localparam int BIT   = 6;
  localparam int LAT   = 20;
  localparam int PB    = PIXEL_BITS;
  localparam int CELLS = PB * BIT;
  localparam int TMO   = 2 * (CELLS + LAT) + 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic          last = 1'b0;
  logic [PB-1:0] data = '0;
  logic          pixel_ready, neopixel_drive, busy, frame_done, underrun;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  neopixel_encoder #(
    .C_T0H_CYCLES   (T0H),
    .C_T1H_CYCLES   (T1H),
    .C_BIT_CYCLES   (BIT),
    .C_LATCH_CYCLES (LAT)
  ) dut (
    .clock_125m     (clk),
    .reset_125m     (rst),
    .pixel_data     (data),
    .pixel_valid    (valid),
    .pixel_last     (last),
    .pixel_ready    (pixel_ready),
    .neopixel_drive (neopixel_drive),
    .busy           (busy),
    .frame_done     (frame_done),
    .underrun       (underrun)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: 0 idle, 1 sending (pixel position m_pos), 2 latching
  int            m_st = 0, m_pos = 0, m_lat = 0;
  logic [PB-1:0] m_word = '0;
  bit            m_last = 0, m_ur = 0, m_inrst = 1;

  initial begin : model
    bit e_drive, e_ready, e_busy, e_fd, e_ur, hs;
    forever begin
      @(negedge clk);
      e_drive = (m_st == 1) &&
                ((m_pos % BIT) < (m_word[PB-1-(m_pos/BIT)] ? T1H : T0H));
      e_ready = !m_inrst && ((m_st == 0) ||
                ((m_st == 1) && (m_pos == CELLS-1) && !m_last));
      e_busy  = (m_st != 0);
      e_fd    = (m_st == 2) && (m_lat == LAT-1);
      e_ur    = m_ur;
      if (chk_en) begin
        vectors++;
        if ({neopixel_drive, pixel_ready, busy, frame_done, underrun} !==
            {e_drive, e_ready, e_busy, e_fd, e_ur}) begin
          miscompares++;
          $display("FAIL model cyc %0d drv/rdy/busy/fd/ur: got %b%b%b%b%b expected %b%b%b%b%b",
                   cyc, neopixel_drive, pixel_ready, busy, frame_done, underrun,
                   e_drive, e_ready, e_busy, e_fd, e_ur);
        end
      end
      // advance with the inputs the next rising edge will sample
      if (rst) begin
        m_st = 0; m_pos = 0; m_lat = 0; m_ur = 0; m_inrst = 1; chk_en = 1;
      end else begin
        hs = valid && e_ready;
        m_inrst = 0;
        m_ur = 0;
        case (m_st)
          0: if (hs) begin m_st = 1; m_pos = 0; m_word = data; m_last = last; end
          1: if (m_pos == CELLS-1) begin
               if (hs) begin m_pos = 0; m_word = data; m_last = last; end
               else begin m_ur = !m_last; m_st = 2; m_lat = 0; end
             end else m_pos++;
          default: if (m_lat == LAT-1) m_st = 0; else m_lat++;
        endcase
      end
    end
  end

  // Present a word and hold it until accepted; returns the handshake cycle
  task automatic send_pixel(input logic [PB-1:0] d, input bit l, output int hcyc);
    bit done = 0;
    int n = 0;
    data = d; last = l; valid = 1'b1; hcyc = -1;
    while (!done && n < TMO) begin
      @(negedge clk);
      n++;
      if (pixel_ready) begin done = 1; hcyc = cyc; end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("handshake_seen", int'(done), 1);
  endtask

  // Wait for frame_done, noting any underrun pulse on the way
  task automatic wait_fd(output int fdc, output int urc);
    bit done = 0;
    int n = 0;
    fdc = -1; urc = -1;
    while (!done && n < TMO) begin
      @(negedge clk);
      n++;
      if (underrun) urc = cyc;
      if (frame_done) begin done = 1; fdc = cyc; end
    end
    check("frame_done_seen", int'(done), 1);
  endtask

  task automatic rand_gap(input int maxc);
    repeat ($urandom_range(0, maxc)) begin @(posedge clk); #1; end
  endtask

  initial begin : stim
    int h, h2, h3, fdc, urc, hc, cnt;
    logic [31:0] r;
    logic [PB-1:0] d1;
    int lit8[8] = '{4, 2, 4, 2, 2, 4, 2, 4};

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(pixel_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drive", int'(neopixel_drive), 0);
    check("rst_frame_done", int'(frame_done), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_ready", int'(pixel_ready), 1);
    @(posedge clk); #1;

    // single pixel: per-cell high times, latch lows, frame_done timing
`ifdef NEOPIXEL_RGBW_EN
    d1 = 32'h000000FF;
`else
    d1 = 24'hA50000;
`endif
    send_pixel(d1, 1'b1, h);
    for (int c = 0; c < PB; c++) begin
      hc = 0;
      repeat (BIT) begin @(negedge clk); hc += int'(neopixel_drive); end
`ifdef NEOPIXEL_RGBW_EN
      check($sformatf("cell%0d_high", c), hc, (c < 24) ? 2 : 4);
`else
      check($sformatf("cell%0d_high", c), hc, (c < 8) ? lit8[c] : 2);
`endif
    end
    hc = 0; fdc = -1;
    repeat (LAT) begin
      @(negedge clk);
      hc += int'(neopixel_drive);
      if (frame_done) fdc = cyc;
    end
    check("latch_highs", hc, 0);
    check("single_fd_cycle", fdc - h, CELLS + LAT);
    @(posedge clk); #1;

    // three back-to-back pixels
    r = $urandom; send_pixel(r[PB-1:0], 1'b0, h);
    r = $urandom; send_pixel(r[PB-1:0], 1'b0, h2);
    r = $urandom; send_pixel(r[PB-1:0], 1'b1, h3);
    check("b2b_gap1", h2 - h, CELLS);
    check("b2b_gap2", h3 - h2, CELLS);
    wait_fd(fdc, urc);
    check("b2b_fd_cycle", fdc - h, 3 * CELLS + LAT);
    check("b2b_no_underrun", urc, -1);
    @(posedge clk); #1;

    // underrun: last=0 and nothing follows
    r = $urandom; send_pixel(r[PB-1:0], 1'b0, h);
    wait_fd(fdc, urc);
    check("underrun_cycle", urc - h, CELLS + 1);
    check("underrun_fd_cycle", fdc - h, CELLS + LAT);
    @(posedge clk); #1;

    // reset mid-bit while drive is high
    send_pixel('1, 1'b1, h);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("pre_rst_drive", int'(neopixel_drive), 1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_drive", int'(neopixel_drive), 0);
    check("post_rst_busy", int'(busy), 0);
    cnt = 0;
    repeat (40) begin @(negedge clk); cnt += int'(frame_done) + int'(underrun); end
    check("post_rst_no_pulse", cnt, 0);
    @(posedge clk); #1;
    r = $urandom; send_pixel(r[PB-1:0], 1'b1, h);
    wait_fd(fdc, urc);
    check("post_rst_fd_cycle", fdc - h, CELLS + LAT);
    @(posedge clk); #1;

    // valid held through LATCH: accepted the cycle after frame_done
    r = $urandom; send_pixel(r[PB-1:0], 1'b1, h);
    r = $urandom; send_pixel(r[PB-1:0], 1'b1, h2);
    check("latch_hold_hs", h2 - h, CELLS + LAT + 1);
    wait_fd(fdc, urc);
    @(posedge clk); #1;

    // random frames with gaps, underruns and occasional aborts
    for (int f = 0; f < 20; f++) begin
      int n = $urandom_range(1, 4);
      bit aborted = 0;
      for (int k = 0; k < n; k++) begin
        rand_gap(2);
        r = $urandom;
        send_pixel(r[PB-1:0], (k == n-1), h);
        if ($urandom_range(0, 9) == 0) begin
          repeat ($urandom_range(1, 60)) @(posedge clk);
          #1; rst = 1'b1;
          @(posedge clk); #1; rst = 1'b0;
          aborted = 1;
          break;
        end
      end
      if (!aborted) wait_fd(fdc, urc);
      rand_gap(3);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
